// File: rtl/seq_shift_add_multiplier_if.sv
// Start/done handshake bundle between the ALU/HI-LO stage (master) and the multiplier (slave).
interface seq_shift_add_multiplier_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  busy, done, product, hi, lo
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output busy, done, product, hi, lo
   );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier (unsigned or two's complement) with start/done handshake.
// Optional MULT_ZERO_SKIP_EN: zero operands bypass the iteration phase.
module seq_shift_add_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input logic                       clk,
   input logic                       rst,
   seq_shift_add_multiplier_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH:0]       sum;
   logic                 zero_skip;

   // Magnitude of -2^(W-1) is 2^(W-1), which still fits as an unsigned W-bit value.
   assign a_abs = (bus.signed_mode && bus.multiplicand[WIDTH-1]) ?
                  (~bus.multiplicand + 1'b1) : bus.multiplicand;
   assign b_abs = (bus.signed_mode && bus.multiplier[WIDTH-1]) ?
                  (~bus.multiplier + 1'b1) : bus.multiplier;

   assign sum = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

`ifdef MULT_ZERO_SKIP_EN
   assign zero_skip = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
   assign zero_skip = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      product_d = product_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               mcand_d = a_abs;
               if (zero_skip) begin
                  product_d = '0;
                  neg_d     = 1'b0;
                  state_d   = StFix;
               end else begin
                  product_d = {{WIDTH{1'b0}}, b_abs};
                  cnt_d     = CNT_W'(WIDTH);
                  neg_d     = bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                  state_d   = StCalc;
               end
            end
         end
         StCalc: begin
            if (product_q[0]) begin
               product_d = {sum, product_q[WIDTH-1:1]};
            end else begin
               product_d = {1'b0, product_q[2*WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (neg_q) begin
               product_d = ~product_q + 1'b1;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         product_q <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         product_q <= product_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign bus.hi      = product_q[2*WIDTH-1:WIDTH];
   assign bus.lo      = product_q[WIDTH-1:0];
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: 32-bit and 8-bit instances, hand-computed results.
module tb_seq_shift_add_multiplier;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   lat;
   int   done_seen;

   always #5 clk = ~clk;

   seq_shift_add_multiplier_if #(.WIDTH(32)) bus32 ();
   seq_shift_add_multiplier_if #(.WIDTH(8))  bus8 ();

   seq_shift_add_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   seq_shift_add_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch32(input logic sm, input logic [31:0] a, input logic [31:0] b);
      bus32.signed_mode  = sm;
      bus32.multiplicand = a;
      bus32.multiplier   = b;
      bus32.start        = 1'b1;
      step();
      bus32.start        = 1'b0;
   endtask

   task automatic launch8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      bus8.signed_mode  = sm;
      bus8.multiplicand = a;
      bus8.multiplier   = b;
      bus8.start        = 1'b1;
      step();
      bus8.start        = 1'b0;
   endtask

   // Counts edges after acceptance until done is seen; gives up at 100.
   task automatic wait_done(input bit w8, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!(w8 ? bus8.done : bus32.done) && n < 100);
   endtask

   initial begin
      bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.multiplicand = '0; bus32.multiplier = '0;
      bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.multiplicand  = '0; bus8.multiplier  = '0;
      step();
      step();
      rst = 1'b0;
      check("reset_product", bus32.product, 64'h0);
      check("reset_busy", {63'b0, bus32.busy}, 64'h0);
      check("reset_done", {63'b0, bus32.done}, 64'h0);

      // T1
      launch32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("t1_busy", {63'b0, bus32.busy}, 64'h1);
      check("t1_done_low", {63'b0, bus32.done}, 64'h0);
      wait_done(1'b0, lat);
      check("t1_latency", 64'(lat), 64'd33);
      check("t1_product", bus32.product, 64'hFFFF_FFFE_0000_0001);
      check("t1_busy_at_done", {63'b0, bus32.busy}, 64'h0);
      step();
      check("t1_done_pulse", {63'b0, bus32.done}, 64'h0);
      check("t1_hold", bus32.product, 64'hFFFF_FFFE_0000_0001);

      // T2
      launch32(1'b1, 32'hFFFF_FFFD, 32'd5);
      wait_done(1'b0, lat);
      check("t2_latency", 64'(lat), 64'd33);
      check("t2_product", bus32.product, 64'hFFFF_FFFF_FFFF_FFF1);
      check("t2_hi", {32'b0, bus32.hi}, 64'hFFFF_FFFF);
      check("t2_lo", {32'b0, bus32.lo}, 64'hFFFF_FFF1);

      // T3: second start issued in the done cycle
      launch32(1'b1, 32'h8000_0000, 32'h8000_0000);
      wait_done(1'b0, lat);
      check("t3_signed", bus32.product, 64'h4000_0000_0000_0000);
      launch32(1'b0, 32'h8000_0000, 32'h8000_0000);
      check("t3_start_in_done_cycle", {63'b0, bus32.busy}, 64'h1);
      wait_done(1'b0, lat);
      check("t3_unsigned_latency", 64'(lat), 64'd33);
      check("t3_unsigned", bus32.product, 64'h4000_0000_0000_0000);

      // T4: start while busy is ignored
      launch32(1'b0, 32'd7, 32'd9);
      repeat (4) step();
      bus32.multiplicand = 32'd100;
      bus32.multiplier   = 32'd100;
      bus32.start        = 1'b1;
      step();
      bus32.start        = 1'b0;
      wait_done(1'b0, lat);
      check("t4_total_latency", 64'(lat + 5), 64'd33);
      check("t4_product", bus32.product, 64'd63);
      step();
      check("t4_no_restart", {63'b0, bus32.busy}, 64'h0);

      // T4: reset mid-operation
      launch32(1'b0, 32'd2, 32'd3);
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t4_rst_product", bus32.product, 64'h0);
      check("t4_rst_busy", {63'b0, bus32.busy}, 64'h0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus32.done) done_seen++;
         step();
      end
      check("t4_rst_no_done", 64'(done_seen), 64'd0);

      // rst and start together: rst wins
      bus32.multiplicand = 32'd5;
      bus32.multiplier   = 32'd5;
      bus32.start        = 1'b1;
      rst                = 1'b1;
      step();
      bus32.start        = 1'b0;
      rst                = 1'b0;
      check("rst_start_busy", {63'b0, bus32.busy}, 64'h0);
      check("rst_start_product", bus32.product, 64'h0);

      // T5: 8-bit instance
      launch8(1'b0, 8'hFF, 8'hFF);
      wait_done(1'b1, lat);
      check("t5_latency", 64'(lat), 64'd9);
      check("t5_unsigned", {48'b0, bus8.product}, 64'hFE01);
      launch8(1'b1, 8'hFF, 8'hFF);
      wait_done(1'b1, lat);
      check("t5_signed", {48'b0, bus8.product}, 64'h0001);
      check("t5_signed_hi", {56'b0, bus8.hi}, 64'h00);
      launch8(1'b1, 8'h80, 8'h03);
      wait_done(1'b1, lat);
      check("t5_min_times_3", {48'b0, bus8.product}, 64'hFE80);

      // T6: zero operand
      launch32(1'b0, 32'd0, 32'h1234);
      wait_done(1'b0, lat);
`ifdef MULT_ZERO_SKIP_EN
      check("t6_latency", 64'(lat), 64'd1);
`else
      check("t6_latency", 64'(lat), 64'd33);
`endif
      check("t6_product", bus32.product, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
